// File: rtl/div_unit.sv
// Iterative integer divider for RV32M-style DIV/DIVU/REM/REMU.
// Restoring radix-2 algorithm, one quotient bit per cycle, with a
// one-cycle shortcut for divide-by-zero and signed overflow.
module div_unit #(
    parameter int unsigned D_WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               Start,
    input  logic [1:0]         Op,
    input  logic [D_WIDTH-1:0] SrcA,
    input  logic [D_WIDTH-1:0] SrcB,
    output logic               Busy,
    output logic               Done,
    output logic [D_WIDTH-1:0] Result
);

    localparam int unsigned XW = D_WIDTH + 1;
    localparam int unsigned CW = (D_WIDTH > 1) ? $clog2(D_WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [D_WIDTH-1:0] result_q, result_d;

    logic [1:0]         op_q, op_d;
    logic [D_WIDTH-1:0] quo_q, quo_d;
    logic [D_WIDTH-1:0] rem_q, rem_d;
    logic [D_WIDTH-1:0] dvs_q, dvs_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               sign_a_q, sign_a_d;
    logic               sign_b_q, sign_b_d;
    logic               special_q, special_d;
    logic [D_WIDTH-1:0] spec_res_q, spec_res_d;

    logic               accept_c;
    logic               special_c;
    logic               in_signed_c;
    logic               in_sign_a_c;
    logic               in_sign_b_c;
    logic               div_zero_c;
    logic               ovf_c;
    logic [D_WIDTH-1:0] a_mag_c;
    logic [D_WIDTH-1:0] b_mag_c;
    logic [XW-1:0]      shifted_c;
    logic               ge_c;
    logic [D_WIDTH-1:0] q_fix_c;
    logic [D_WIDTH-1:0] r_fix_c;

    localparam logic [D_WIDTH-1:0] MOST_NEG = {1'b1, {(D_WIDTH-1){1'b0}}};

    // Decode of incoming request: acceptance, sign handling and special cases
    always_comb begin
        accept_c    = Start && ((state_q == S_IDLE) || (state_q == S_DONE));
        in_signed_c = ~Op[0];
        in_sign_a_c = in_signed_c & SrcA[D_WIDTH-1];
        in_sign_b_c = in_signed_c & SrcB[D_WIDTH-1];
        div_zero_c  = (SrcB == '0);
        ovf_c       = in_signed_c && (SrcA == MOST_NEG) && (SrcB == '1);
        special_c   = div_zero_c || ovf_c;
        // Magnitudes are formed at D_WIDTH+1 bits; the most-negative value wraps onto itself
        a_mag_c = in_sign_a_c ? D_WIDTH'(XW'(0) - {1'b0, SrcA}) : SrcA;
        b_mag_c = in_sign_b_c ? D_WIDTH'(XW'(0) - {1'b0, SrcB}) : SrcB;
    end

    // One restoring step: shift in next dividend bit, subtract divisor if it fits
    always_comb begin
        shifted_c = {rem_q, quo_q[D_WIDTH-1]};
        ge_c      = (shifted_c >= {1'b0, dvs_q});
    end

    // Sign correction of the raw unsigned quotient and remainder
    always_comb begin
        q_fix_c = quo_q;
        r_fix_c = rem_q;
        if (~op_q[0] && (sign_a_q ^ sign_b_q)) begin
            q_fix_c = D_WIDTH'(XW'(0) - {1'b0, quo_q});
        end
        if (~op_q[0] && sign_a_q) begin
            r_fix_c = D_WIDTH'(XW'(0) - {1'b0, rem_q});
        end
    end

    // State register and registered status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (accept_c) state_d = special_c ? S_FIX : S_RUN;
            S_RUN:  if (cnt_q == '0) state_d = S_FIX;
            S_FIX:  state_d = S_DONE;
            S_DONE: begin
                if (accept_c) state_d = special_c ? S_FIX : S_RUN;
                else          state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Status outputs follow the state being entered so they are registered with it
    always_comb begin
        busy_d = (state_d == S_RUN) || (state_d == S_FIX);
        done_d = (state_d == S_DONE);
    end

    // Datapath next-state: operand latch, iteration, result load
    always_comb begin
        op_d       = op_q;
        quo_d      = quo_q;
        rem_d      = rem_q;
        dvs_d      = dvs_q;
        cnt_d      = cnt_q;
        sign_a_d   = sign_a_q;
        sign_b_d   = sign_b_q;
        special_d  = special_q;
        spec_res_d = spec_res_q;
        result_d   = result_q;

        if (accept_c) begin
            op_d      = Op;
            quo_d     = a_mag_c;
            rem_d     = '0;
            dvs_d     = b_mag_c;
            cnt_d     = CW'(D_WIDTH - 1);
            sign_a_d  = in_sign_a_c;
            sign_b_d  = in_sign_b_c;
            special_d = special_c;
            if (div_zero_c) spec_res_d = Op[1] ? SrcA : '1;
            else            spec_res_d = Op[1] ? '0 : MOST_NEG;
        end else if (state_q == S_RUN) begin
            rem_d = ge_c ? D_WIDTH'(shifted_c - {1'b0, dvs_q}) : D_WIDTH'(shifted_c);
            quo_d = D_WIDTH'({quo_q, ge_c});
            cnt_d = cnt_q - CW'(1);
        end else if (state_q == S_FIX) begin
            if (special_q)    result_d = spec_res_q;
            else if (op_q[1]) result_d = r_fix_c;
            else              result_d = q_fix_c;
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q       <= '0;
            quo_q      <= '0;
            rem_q      <= '0;
            dvs_q      <= '0;
            cnt_q      <= '0;
            sign_a_q   <= 1'b0;
            sign_b_q   <= 1'b0;
            special_q  <= 1'b0;
            spec_res_q <= '0;
            result_q   <= '0;
        end else begin
            op_q       <= op_d;
            quo_q      <= quo_d;
            rem_q      <= rem_d;
            dvs_q      <= dvs_d;
            cnt_q      <= cnt_d;
            sign_a_q   <= sign_a_d;
            sign_b_q   <= sign_b_d;
            special_q  <= special_d;
            spec_res_q <= spec_res_d;
            result_q   <= result_d;
        end
    end

    assign Busy   = busy_q;
    assign Done   = done_q;
    assign Result = result_q;

endmodule
